// File: rtl/bus_map_pkg.sv
// rtl/bus_map_pkg.sv - address map, slave index and data widths for the system bus
package bus_map_pkg;

    localparam logic [31:0] CLINT_BASE = 32'h0200_0000;
    localparam logic [31:0] CLINT_MASK = 32'hFFFF_0000;
    localparam logic [31:0] UART_BASE  = 32'h1000_0000;
    localparam logic [31:0] UART_MASK  = 32'hFFFF_F000;
    localparam logic [31:0] PLIC_BASE  = 32'h0C00_0000;
    localparam logic [31:0] PLIC_MASK  = 32'hFC00_0000;
    localparam logic [31:0] DMEM_BASE  = 32'h8000_0000;
    localparam logic [31:0] DMEM_MASK  = 32'hF000_0000;

    localparam int DATA_W       = 64;
    localparam int CLINT_RDATA_W = 64;
    localparam int UART_RDATA_W  = 8;
    localparam int PLIC_RDATA_W  = 32;
    localparam int DMEM_RDATA_W  = 64;

    typedef enum logic [2:0] {
        SLV_CLINT,
        SLV_UART,
        SLV_PLIC,
        SLV_DMEM,
        SLV_NONE
    } slave_e;

endpackage

// File: rtl/bus_addr_decoder.sv
// rtl/bus_addr_decoder.sv - fixed-priority address decode to one-hot slave select
module bus_addr_decoder
    import bus_map_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] addr,
    output logic [3:0]      sel,
    output logic            unmapped,
    output slave_e          slave
);

    logic hit_clint;
    logic hit_uart;
    logic hit_plic;
    logic hit_dmem;

    assign hit_clint = (addr & XLEN'(CLINT_MASK)) == XLEN'(CLINT_BASE);
    assign hit_uart  = (addr & XLEN'(UART_MASK))  == XLEN'(UART_BASE);
    assign hit_plic  = (addr & XLEN'(PLIC_MASK))  == XLEN'(PLIC_BASE);
    assign hit_dmem  = (addr & XLEN'(DMEM_MASK))  == XLEN'(DMEM_BASE);

    // sel bit order: [0] CLINT, [1] UART, [2] PLIC, [3] DMEM; earlier bits win on overlap
    always_comb begin
        sel   = 4'b0000;
        slave = SLV_NONE;
        if (hit_clint) begin
            sel   = 4'b0001;
            slave = SLV_CLINT;
        end else if (hit_uart) begin
            sel   = 4'b0010;
            slave = SLV_UART;
        end else if (hit_plic) begin
            sel   = 4'b0100;
            slave = SLV_PLIC;
        end else if (hit_dmem) begin
            sel   = 4'b1000;
            slave = SLV_DMEM;
        end
    end

    assign unmapped = (sel == 4'b0000);

endmodule

// File: rtl/simple_bus_interconnect.sv
// rtl/simple_bus_interconnect.sv - single-master bus to CLINT/UART/PLIC/DMEM
// Optional registered unmapped-access capture with BUS_ERR_CAPTURE_EN.
module simple_bus_interconnect
    import bus_map_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              master_req_valid,
    input  logic [XLEN-1:0]   master_req_addr,
    input  logic [63:0]       master_req_wdata,
    input  logic              master_req_we,
    input  logic [2:0]        master_req_size,
    output logic              master_req_ready,
    output logic [63:0]       master_req_rdata,

    output logic              clint_req_valid,
    output logic [15:0]       clint_req_addr,
    output logic [63:0]       clint_req_wdata,
    output logic              clint_req_we,
    output logic [2:0]        clint_req_size,
    input  logic              clint_req_ready,
    input  logic [63:0]       clint_req_rdata,

    output logic              uart_req_valid,
    output logic [2:0]        uart_req_addr,
    output logic [7:0]        uart_req_wdata,
    output logic              uart_req_we,
    input  logic              uart_req_ready,
    input  logic [7:0]        uart_req_rdata,

    output logic              dmem_req_valid,
    output logic [XLEN-1:0]   dmem_req_addr,
    output logic [63:0]       dmem_req_wdata,
    output logic              dmem_req_we,
    output logic [2:0]        dmem_req_size,
    input  logic              dmem_req_ready,
    input  logic [63:0]       dmem_req_rdata,

    output logic              plic_req_valid,
    output logic [XLEN-1:0]   plic_req_addr,
    output logic [31:0]       plic_req_wdata,
    output logic              plic_req_we,
    input  logic              plic_req_ready,
    input  logic [31:0]       plic_req_rdata
`ifdef BUS_ERR_CAPTURE_EN
    ,
    output logic              bus_err,
    output logic [XLEN-1:0]   bus_err_addr
`endif
);

    logic [3:0] sel;
    logic       unmapped;
    slave_e     slave;

    bus_addr_decoder #(.XLEN(XLEN)) u_decoder (
        .addr     (master_req_addr),
        .sel      (sel),
        .unmapped (unmapped),
        .slave    (slave)
    );

    assign clint_req_valid = master_req_valid & sel[0];
    assign uart_req_valid  = master_req_valid & sel[1];
    assign plic_req_valid  = master_req_valid & sel[2];
    assign dmem_req_valid  = master_req_valid & sel[3];

    // Payload fans out to every slave; each one qualifies it with its own valid.
    assign clint_req_addr  = master_req_addr[15:0];
    assign clint_req_wdata = master_req_wdata;
    assign clint_req_we    = master_req_we;
    assign clint_req_size  = master_req_size;

    assign uart_req_addr   = master_req_addr[2:0];
    assign uart_req_wdata  = master_req_wdata[7:0];
    assign uart_req_we     = master_req_we;

    assign dmem_req_addr   = master_req_addr;
    assign dmem_req_wdata  = master_req_wdata;
    assign dmem_req_we     = master_req_we;
    assign dmem_req_size   = master_req_size;

    assign plic_req_addr   = master_req_addr;
    assign plic_req_wdata  = master_req_wdata[31:0];
    assign plic_req_we     = master_req_we;

    always_comb begin
        master_req_ready = 1'b0;
        master_req_rdata = '0;
        case (slave)
            SLV_CLINT: begin
                master_req_ready = clint_req_ready;
                master_req_rdata = clint_req_rdata;
            end
            SLV_UART: begin
                master_req_ready = uart_req_ready;
                master_req_rdata = {{(DATA_W-UART_RDATA_W){1'b0}}, uart_req_rdata};
            end
            SLV_PLIC: begin
                master_req_ready = plic_req_ready;
                master_req_rdata = {{(DATA_W-PLIC_RDATA_W){1'b0}}, plic_req_rdata};
            end
            SLV_DMEM: begin
                master_req_ready = dmem_req_ready;
                master_req_rdata = dmem_req_rdata;
            end
            default: begin
                master_req_ready = master_req_valid;
            end
        endcase
        if (!master_req_valid) begin
            master_req_rdata = '0;
        end
    end

`ifdef BUS_ERR_CAPTURE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_err      <= 1'b0;
            bus_err_addr <= '0;
        end else if (master_req_valid && unmapped) begin
            bus_err      <= 1'b1;
            bus_err_addr <= master_req_addr;
        end
    end
`else
    // Clock, reset and the unmapped flag only feed the capture registers.
    logic unused_err_capture;
    assign unused_err_capture = &{1'b0, clk, reset, unmapped};
`endif

endmodule

// File: tb/tb_simple_bus_interconnect.sv
// tb/tb_simple_bus_interconnect.sv - directed self-checking bench for simple_bus_interconnect
module tb_simple_bus_interconnect;

    logic        clk = 1'b0;
    logic        reset;
    logic        master_req_valid;
    logic [31:0] master_req_addr;
    logic [63:0] master_req_wdata;
    logic        master_req_we;
    logic [2:0]  master_req_size;
    logic        master_req_ready;
    logic [63:0] master_req_rdata;

    logic        clint_req_valid;
    logic [15:0] clint_req_addr;
    logic [63:0] clint_req_wdata;
    logic        clint_req_we;
    logic [2:0]  clint_req_size;
    logic        clint_req_ready;
    logic [63:0] clint_req_rdata;

    logic        uart_req_valid;
    logic [2:0]  uart_req_addr;
    logic [7:0]  uart_req_wdata;
    logic        uart_req_we;
    logic        uart_req_ready;
    logic [7:0]  uart_req_rdata;

    logic        dmem_req_valid;
    logic [31:0] dmem_req_addr;
    logic [63:0] dmem_req_wdata;
    logic        dmem_req_we;
    logic [2:0]  dmem_req_size;
    logic        dmem_req_ready;
    logic [63:0] dmem_req_rdata;

    logic        plic_req_valid;
    logic [31:0] plic_req_addr;
    logic [31:0] plic_req_wdata;
    logic        plic_req_we;
    logic        plic_req_ready;
    logic [31:0] plic_req_rdata;

`ifdef BUS_ERR_CAPTURE_EN
    logic        bus_err;
    logic [31:0] bus_err_addr;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [63:0] CLINT_DATA = 64'h1111_2222_3333_4444;

    always #5 clk = ~clk;

    simple_bus_interconnect dut (
        .clk              (clk),
        .reset            (reset),
        .master_req_valid (master_req_valid),
        .master_req_addr  (master_req_addr),
        .master_req_wdata (master_req_wdata),
        .master_req_we    (master_req_we),
        .master_req_size  (master_req_size),
        .master_req_ready (master_req_ready),
        .master_req_rdata (master_req_rdata),
        .clint_req_valid  (clint_req_valid),
        .clint_req_addr   (clint_req_addr),
        .clint_req_wdata  (clint_req_wdata),
        .clint_req_we     (clint_req_we),
        .clint_req_size   (clint_req_size),
        .clint_req_ready  (clint_req_ready),
        .clint_req_rdata  (clint_req_rdata),
        .uart_req_valid   (uart_req_valid),
        .uart_req_addr    (uart_req_addr),
        .uart_req_wdata   (uart_req_wdata),
        .uart_req_we      (uart_req_we),
        .uart_req_ready   (uart_req_ready),
        .uart_req_rdata   (uart_req_rdata),
        .dmem_req_valid   (dmem_req_valid),
        .dmem_req_addr    (dmem_req_addr),
        .dmem_req_wdata   (dmem_req_wdata),
        .dmem_req_we      (dmem_req_we),
        .dmem_req_size    (dmem_req_size),
        .dmem_req_ready   (dmem_req_ready),
        .dmem_req_rdata   (dmem_req_rdata),
        .plic_req_valid   (plic_req_valid),
        .plic_req_addr    (plic_req_addr),
        .plic_req_wdata   (plic_req_wdata),
        .plic_req_we      (plic_req_we),
        .plic_req_ready   (plic_req_ready),
        .plic_req_rdata   (plic_req_rdata)
`ifdef BUS_ERR_CAPTURE_EN
        ,
        .bus_err          (bus_err),
        .bus_err_addr     (bus_err_addr)
`endif
    );

    // Slave mocks: UART echoes its offset, DMEM answers one cycle after valid.
    assign clint_req_rdata = CLINT_DATA;
    assign uart_req_ready  = uart_req_valid;
    assign uart_req_rdata  = {5'b0, uart_req_addr};
    assign plic_req_ready  = plic_req_valid;
    assign dmem_req_rdata  = {32'hDEADBEEF, dmem_req_addr};

    always_ff @(posedge clk) begin
        if (reset) dmem_req_ready <= 1'b0;
        else       dmem_req_ready <= dmem_req_valid & ~dmem_req_ready;
    end

    task automatic drive(input logic [31:0] a, input logic [63:0] d, input logic w);
        @(negedge clk);
        master_req_valid = 1'b1;
        master_req_addr  = a;
        master_req_wdata = d;
        master_req_we    = w;
        master_req_size  = 3'd3;
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        master_req_valid = 1'b0;
        master_req_addr  = 32'h0;
        master_req_wdata = 64'h0;
        master_req_we    = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        n_cmp++;
        if ({clint_req_valid, uart_req_valid, plic_req_valid, dmem_req_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_valids: got %b want 0000",
                     {clint_req_valid, uart_req_valid, plic_req_valid, dmem_req_valid});
        end
        n_cmp++;
        if (master_req_ready !== 1'b0 || master_req_rdata !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_idle_resp: ready=%b rdata=%h want 0/0", master_req_ready, master_req_rdata);
        end
        // Unmapped access during reset still completes combinationally.
        drive(32'h5000_0000, 64'h0, 1'b0);
        n_cmp++;
        if (master_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_comb_ready: got %b want 1", master_req_ready);
        end
        @(posedge clk); #1;
`ifdef BUS_ERR_CAPTURE_EN
        n_cmp++;
        if (bus_err !== 1'b0 || bus_err_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_bus_err: got %b/%h want 0/0", bus_err, bus_err_addr);
        end
`endif
        idle();
        reset = 1'b0;
        // Mapped address with valid low must return zero data.
        @(negedge clk);
        master_req_addr = 32'h0200_0000;
        #1;
        n_cmp++;
        if (clint_req_valid !== 1'b0 || master_req_rdata !== 64'h0) begin
            n_fail++;
            $display("FAIL novalid_rdata: valid=%b rdata=%h want 0/0", clint_req_valid, master_req_rdata);
        end
    endtask

    task automatic test_clint();
        logic [31:0] addrs [3];
        logic [15:0] offs  [3];
        addrs = '{32'h0200_0000, 32'h0200_4000, 32'h0200_BFF8};
        offs  = '{16'h0000, 16'h4000, 16'hBFF8};
        clint_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(addrs[i], 64'h0, 1'b0);
            n_cmp++;
            if (clint_req_valid !== 1'b1 || clint_req_addr !== offs[i]) begin
                n_fail++;
                $display("FAIL clint_sel_%0d: valid=%b addr=%h want 1/%h", i, clint_req_valid, clint_req_addr, offs[i]);
            end
            n_cmp++;
            if ({uart_req_valid, plic_req_valid, dmem_req_valid} !== 3'b000) begin
                n_fail++;
                $display("FAIL clint_others_%0d: got %b want 000", i, {uart_req_valid, plic_req_valid, dmem_req_valid});
            end
            n_cmp++;
            if (master_req_ready !== 1'b1 || master_req_rdata !== CLINT_DATA) begin
                n_fail++;
                $display("FAIL clint_resp_%0d: ready=%b rdata=%h want 1/%h", i, master_req_ready, master_req_rdata, CLINT_DATA);
            end
        end
        idle();
    endtask

    task automatic test_uart();
        drive(32'h1000_0007, 64'h0, 1'b0);
        n_cmp++;
        if (uart_req_valid !== 1'b1 || uart_req_addr !== 3'd7) begin
            n_fail++;
            $display("FAIL uart_sel: valid=%b addr=%0d want 1/7", uart_req_valid, uart_req_addr);
        end
        n_cmp++;
        if (master_req_ready !== 1'b1 || master_req_rdata !== 64'h7) begin
            n_fail++;
            $display("FAIL uart_resp: ready=%b rdata=%h want 1/0000000000000007", master_req_ready, master_req_rdata);
        end
        idle();
    endtask

    task automatic test_plic();
        logic [31:0] addrs [3];
        addrs = '{32'h0C00_0004, 32'h0C00_2000, 32'h0C20_0000};
        plic_req_rdata = 32'hA520_0000;
        for (int i = 0; i < 3; i++) begin
            drive(addrs[i], 64'h0, 1'b0);
            n_cmp++;
            if (plic_req_valid !== 1'b1 || plic_req_addr !== addrs[i] || clint_req_valid !== 1'b0 || dmem_req_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL plic_sel_%0d: valid=%b addr=%h want 1/%h", i, plic_req_valid, plic_req_addr, addrs[i]);
            end
            n_cmp++;
            if (master_req_rdata !== 64'h0000_0000_A520_0000) begin
                n_fail++;
                $display("FAIL plic_rdata_%0d: got %h want 00000000a5200000", i, master_req_rdata);
            end
        end
        idle();
    endtask

    task automatic test_dmem();
        drive(32'h8000_1234, 64'h0, 1'b0);
        n_cmp++;
        if (dmem_req_valid !== 1'b1 || master_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL dmem_wait: valid=%b ready=%b want 1/0", dmem_req_valid, master_req_ready);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (dmem_req_ready !== 1'b1 || master_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL dmem_ready: slave=%b master=%b want 1/1", dmem_req_ready, master_req_ready);
        end
        n_cmp++;
        if (master_req_rdata !== 64'hDEADBEEF_8000_1234) begin
            n_fail++;
            $display("FAIL dmem_rdata: got %h want deadbeef80001234", master_req_rdata);
        end
        idle();
    endtask

    task automatic test_unmapped();
        logic [31:0] addrs [2];
        addrs = '{32'h5000_0000, 32'h0000_1000};
        for (int i = 0; i < 2; i++) begin
            drive(addrs[i], 64'hFFFF, 1'b0);
            n_cmp++;
            if (master_req_ready !== 1'b1 || master_req_rdata !== 64'h0) begin
                n_fail++;
                $display("FAIL unmapped_resp_%0d: ready=%b rdata=%h want 1/0", i, master_req_ready, master_req_rdata);
            end
            n_cmp++;
            if ({clint_req_valid, uart_req_valid, plic_req_valid, dmem_req_valid} !== 4'b0000) begin
                n_fail++;
                $display("FAIL unmapped_valids_%0d: got %b want 0000", i,
                         {clint_req_valid, uart_req_valid, plic_req_valid, dmem_req_valid});
            end
`ifdef BUS_ERR_CAPTURE_EN
            @(posedge clk); #1;
            n_cmp++;
            if (bus_err !== 1'b1 || bus_err_addr !== addrs[i]) begin
                n_fail++;
                $display("FAIL bus_err_%0d: got %b/%h want 1/%h", i, bus_err, bus_err_addr, addrs[i]);
            end
`endif
            idle();
        end
`ifdef BUS_ERR_CAPTURE_EN
        drive(32'h8000_0000, 64'h0, 1'b0);
        @(posedge clk); #1;
        n_cmp++;
        if (bus_err !== 1'b1 || bus_err_addr !== 32'h0000_1000) begin
            n_fail++;
            $display("FAIL bus_err_sticky: got %b/%h want 1/00001000", bus_err, bus_err_addr);
        end
        idle();
`endif
    endtask

    task automatic test_back_to_back();
        clint_req_ready = 1'b0;
        drive(32'h0200_0000, 64'h1, 1'b1);
        for (int c = 0; c < 2; c++) begin
            n_cmp++;
            if (clint_req_valid !== 1'b1 || clint_req_we !== 1'b1 || clint_req_wdata !== 64'h1 || master_req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL clint_write_hold_%0d: valid=%b we=%b wdata=%h ready=%b want 1/1/1/0",
                         c, clint_req_valid, clint_req_we, clint_req_wdata, master_req_ready);
            end
            @(negedge clk); #1;
        end
        clint_req_ready = 1'b1;
        #1;
        n_cmp++;
        if (master_req_ready !== 1'b1 || clint_req_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL clint_write_done: ready=%b valid=%b want 1/1", master_req_ready, clint_req_valid);
        end
        drive(32'h1000_0000, 64'h41, 1'b1);
        n_cmp++;
        if (uart_req_valid !== 1'b1 || uart_req_wdata !== 8'h41 || uart_req_we !== 1'b1 || clint_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL uart_write: valid=%b wdata=%h we=%b clint=%b want 1/41/1/0",
                     uart_req_valid, uart_req_wdata, uart_req_we, clint_req_valid);
        end
        n_cmp++;
        if (master_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL uart_write_ready: got %b want 1", master_req_ready);
        end
        idle();
    endtask

    initial begin
        reset            = 1'b1;
        master_req_valid = 1'b0;
        master_req_addr  = 32'h0;
        master_req_wdata = 64'h0;
        master_req_we    = 1'b0;
        master_req_size  = 3'd3;
        clint_req_ready  = 1'b1;
        plic_req_rdata   = 32'h0;

        test_reset();
        test_clint();
        test_uart();
        test_plic();
        test_dmem();
        test_unmapped();
        test_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
